// File: rtl/id_stage_fwd.sv
// Decode stage: register file, EX/MEM/WB forwarding, load-use stall, early branch compare; ID/EX register adds 1 cycle.
// A load-use hazard holds PC and IF/ID via stall for one cycle and sends a bubble to EX; flush overrides stall.
module id_stage_fwd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   pc4,
  input  logic [31:0]   inst,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_regrt,
  input  logic          d_sext,
  input  logic [2:0]    d_aluc,
  input  logic          d_usesrs,
  input  logic          d_usesrt,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [AW-1:0] ex_rn,
  input  logic [DW-1:0] ex_alu,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [AW-1:0] mem_rn,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_mdo,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_rn,
  input  logic [DW-1:0] wdi,
  input  logic          flush,
  output logic          stall,
  output logic          rsrtequ,
  output logic [31:0]   bpc,
  output logic [31:0]   jpc,
  output logic          e_valid,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          e_aluimm,
  output logic          e_shift,
  output logic [2:0]    e_aluc,
  output logic [AW-1:0] e_rn,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [DW-1:0] e_imm,
  output logic [15:0]   perf_stall
);

  logic [AW-1:0] rs, rt, rd, rn;
  logic [DW-1:0] regs [2**AW];
  logic [DW-1:0] opa, opb, imm;
  logic          hazard;
  logic          unused_ok;

  assign rs = AW'(inst[9:5]);
  assign rt = AW'(inst[4:0]);
  assign rd = AW'(inst[14:10]);
  assign rn = d_regrt ? rt : rd;
  assign unused_ok = ^inst[31:26];

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (wb_wreg && wb_rn != '0) begin
      regs[wb_rn] <= wdi;
    end
  end

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] rf);
    if (r == '0)                             return '0;
    if (ex_wreg && !ex_m2reg && ex_rn == r)  return ex_alu;
    if (mem_wreg && mem_rn == r)             return mem_m2reg ? mem_mdo : mem_alu;
    if (wb_wreg && wb_rn == r)               return wdi;
    return rf;
  endfunction

  assign opa = fwd(rs, regs[rs]);
  assign opb = fwd(rt, regs[rt]);

  assign rsrtequ = (opa == opb);
  assign imm     = {{(DW-16){d_sext & inst[25]}}, inst[25:10]};
  assign bpc     = pc4 + {{14{inst[25]}}, inst[25:10], 2'b00};
  assign jpc     = {pc4[31:28], inst[25:0], 2'b00};

  // A load in EX cannot be forwarded yet; wait one cycle for it to reach MEM.
  assign hazard = ex_wreg && ex_m2reg && ex_rn != '0 &&
                  ((d_usesrs && ex_rn == rs) || (d_usesrt && ex_rn == rt));
  assign stall  = hazard && !flush;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_aluc   <= '0;
      e_rn     <= '0;
      e_a      <= '0;
      e_b      <= '0;
      e_imm    <= '0;
    end else if (flush || hazard) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_aluc   <= '0;
      e_rn     <= '0;
      e_a      <= '0;
      e_b      <= '0;
      e_imm    <= '0;
    end else begin
      e_valid  <= 1'b1;
      e_wreg   <= d_wreg;
      e_m2reg  <= d_m2reg;
      e_wmem   <= d_wmem;
      e_aluimm <= d_aluimm;
      e_shift  <= d_shift;
      e_aluc   <= d_aluc;
      e_rn     <= rn;
      e_a      <= opa;
      e_b      <= opb;
      e_imm    <= imm;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                         perf_stall <= '0;
    else if (stall && perf_stall != '1) perf_stall <= perf_stall + 16'd1;
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed-vector bench for id_stage_fwd: forwarding, load-use stall, r0, branch targets, flush and reset.
module tb_id_stage_fwd;
  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc4, inst;
  logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_regrt, d_sext;
  logic [2:0]  d_aluc;
  logic        d_usesrs, d_usesrt;
  logic        ex_wreg, ex_m2reg;
  logic [4:0]  ex_rn;
  logic [31:0] ex_alu;
  logic        mem_wreg, mem_m2reg;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu, mem_mdo;
  logic        wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wdi;
  logic        flush;
  logic        stall, rsrtequ;
  logic [31:0] bpc, jpc;
  logic        e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift;
  logic [2:0]  e_aluc;
  logic [4:0]  e_rn;
  logic [31:0] e_a, e_b, e_imm;
  logic [15:0] perf_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_fwd #(.DW(32), .AW(5)) dut (
    .clk(clk), .clrn(clrn), .pc4(pc4), .inst(inst),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_aluimm(d_aluimm),
    .d_shift(d_shift), .d_regrt(d_regrt), .d_sext(d_sext), .d_aluc(d_aluc),
    .d_usesrs(d_usesrs), .d_usesrt(d_usesrt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
    .mem_alu(mem_alu), .mem_mdo(mem_mdo),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wdi(wdi), .flush(flush),
    .stall(stall), .rsrtequ(rsrtequ), .bpc(bpc), .jpc(jpc),
    .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_aluimm(e_aluimm), .e_shift(e_shift), .e_aluc(e_aluc), .e_rn(e_rn),
    .e_a(e_a), .e_b(e_b), .e_imm(e_imm), .perf_stall(perf_stall)
  );

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {17'd0, rd, rs, rt};
  endfunction

  task automatic idle();
    pc4 = 32'h0; inst = 32'h0;
    d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_regrt = 0; d_sext = 0;
    d_aluc = 3'd0; d_usesrs = 0; d_usesrt = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 5'd0; ex_alu = 32'h0;
    mem_wreg = 0; mem_m2reg = 0; mem_rn = 5'd0; mem_alu = 32'h0; mem_mdo = 32'h0;
    wb_wreg = 0; wb_rn = 5'd0; wdi = 32'h0; flush = 0;
  endtask

  task automatic test_reset();
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL reset_e_valid: got %b exp 0", e_valid); end
    checks++; if (e_a !== 32'h0) begin errors++; $display("FAIL reset_e_a: got %h exp 0", e_a); end
    checks++; if (e_rn !== 5'h0) begin errors++; $display("FAIL reset_e_rn: got %h exp 0", e_rn); end
    checks++; if (perf_stall !== 16'h0) begin errors++; $display("FAIL reset_perf: got %0d exp 0", perf_stall); end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    idle();
    inst = mk(5'd3, 5'd0, 5'd4); d_usesrs = 1; d_wreg = 1; d_aluc = 3'd2;
    wb_wreg = 1; wb_rn = 5'd3; wdi = 32'h11;
    mem_wreg = 1; mem_rn = 5'd3; mem_alu = 32'h22;
    ex_wreg = 1; ex_rn = 5'd3; ex_alu = 32'h33;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h33) begin errors++; $display("FAIL fwd_ex: got %h exp 33", e_a); end
    checks++; if (e_valid !== 1'b1 || e_rn !== 5'd4 || e_wreg !== 1'b1 || e_aluc !== 3'd2)
      begin errors++; $display("FAIL fwd_ctrl: got v=%b rn=%0d w=%b aluc=%0d exp 1 4 1 2", e_valid, e_rn, e_wreg, e_aluc); end
    @(negedge clk); ex_wreg = 0;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h22) begin errors++; $display("FAIL fwd_mem: got %h exp 22", e_a); end
    @(negedge clk); mem_m2reg = 1; mem_mdo = 32'h44;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h44) begin errors++; $display("FAIL fwd_mem_mdo: got %h exp 44", e_a); end
    @(negedge clk); mem_wreg = 0;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h11) begin errors++; $display("FAIL fwd_wb: got %h exp 11", e_a); end
    @(negedge clk); wb_wreg = 0;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h11) begin errors++; $display("FAIL fwd_array: got %h exp 11", e_a); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    inst = mk(5'd0, 5'd5, 5'd6); d_usesrt = 1; d_wreg = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd5; ex_alu = 32'h99;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
    @(posedge clk); #1;
    checks++; if (e_valid !== 1'b0 || e_b !== 32'h0 || e_wreg !== 1'b0)
      begin errors++; $display("FAIL lu_bubble: got v=%b b=%h w=%b exp 0 0 0", e_valid, e_b, e_wreg); end
    checks++; if (perf_stall !== 16'd1) begin errors++; $display("FAIL lu_perf1: got %0d exp 1", perf_stall); end
    @(negedge clk);
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 5'd0;
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd5; mem_mdo = 32'hDEADBEEF; mem_alu = 32'h1234;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_end: got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (e_b !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_e_b: got %h exp deadbeef", e_b); end
    checks++; if (e_valid !== 1'b1 || e_rn !== 5'd6) begin errors++; $display("FAIL lu_valid: got v=%b rn=%0d exp 1 6", e_valid, e_rn); end
    checks++; if (perf_stall !== 16'd1) begin errors++; $display("FAIL lu_perf: got %0d exp 1", perf_stall); end
  endtask

  task automatic test_r0_guard();
    @(negedge clk);
    idle();
    inst = mk(5'd0, 5'd0, 5'd7); d_usesrs = 1;
    ex_wreg = 1; ex_rn = 5'd0; ex_alu = 32'h55;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h0) begin errors++; $display("FAIL r0_e_a: got %h exp 0", e_a); end
    @(negedge clk); ex_m2reg = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_load_stall: got %b exp 0", stall); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    wb_wreg = 1; wb_rn = 5'd1; wdi = 32'd7;
    @(negedge clk); wb_rn = 5'd2;
    @(negedge clk); wb_wreg = 0;
    pc4 = 32'h100; inst = {6'd0, 16'hFFFF, 5'd1, 5'd2}; d_sext = 1; d_usesrs = 1; d_usesrt = 1;
    #1;
    checks++; if (rsrtequ !== 1'b1) begin errors++; $display("FAIL br_equ: got %b exp 1", rsrtequ); end
    checks++; if (bpc !== 32'hFC) begin errors++; $display("FAIL br_bpc: got %h exp fc", bpc); end
    @(posedge clk); #1;
    checks++; if (e_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL br_imm_sext: got %h exp ffffffff", e_imm); end
    @(negedge clk); d_sext = 0;
    @(posedge clk); #1;
    checks++; if (e_imm !== 32'h0000FFFF) begin errors++; $display("FAIL br_imm_zext: got %h exp 0000ffff", e_imm); end
    @(negedge clk); ex_wreg = 1; ex_rn = 5'd1; ex_alu = 32'd9;
    #1;
    checks++; if (rsrtequ !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL br_ex_ne: got equ=%b stall=%b exp 0 0", rsrtequ, stall); end
    @(negedge clk); ex_alu = 32'd7; ex_rn = 5'd2;
    #1;
    checks++; if (rsrtequ !== 1'b1) begin errors++; $display("FAIL br_ex_eq: got %b exp 1", rsrtequ); end
    @(negedge clk); idle(); pc4 = 32'h100; inst = 32'h10;
    #1;
    checks++; if (jpc !== 32'h40) begin errors++; $display("FAIL jpc: got %h exp 40", jpc); end
    @(negedge clk); pc4 = 32'hA000_0000; inst = 32'h0000_0003;
    #1;
    checks++; if (jpc !== 32'hA000_000C) begin errors++; $display("FAIL jpc_hi: got %h exp a000000c", jpc); end
  endtask

  task automatic test_flush_hazard();
    @(negedge clk);
    idle();
    inst = mk(5'd5, 5'd0, 5'd8); d_usesrs = 1; d_wreg = 1;
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd5;
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (e_valid !== 1'b0 || e_rn !== 5'd0) begin errors++; $display("FAIL fl_bubble: got v=%b rn=%0d exp 0 0", e_valid, e_rn); end
    checks++; if (perf_stall !== 16'd1) begin errors++; $display("FAIL fl_perf: got %0d exp 1", perf_stall); end
    @(negedge clk); ex_wreg = 0; ex_m2reg = 0;
    @(posedge clk); #1;
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL fl_only: got %b exp 0", e_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      wb_wreg = 1; wb_rn = 5'(i); wdi = 32'h100 + 32'(i);
    end
    @(negedge clk);
    idle();
    inst = mk(5'd1, 5'd0, 5'd2); d_usesrs = 1; d_wreg = 1;
    @(posedge clk); #1;
    checks++; if (e_a !== 32'h101 || e_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got a=%h v=%b exp 101 1", e_a, e_valid); end
    #2 clrn = 0;
    #1;
    checks++; if (e_valid !== 1'b0 || e_a !== 32'h0 || e_rn !== 5'd0 || e_wreg !== 1'b0)
      begin errors++; $display("FAIL mid_e: got v=%b a=%h rn=%0d w=%b exp all 0", e_valid, e_a, e_rn, e_wreg); end
    checks++; if (perf_stall !== 16'h0) begin errors++; $display("FAIL mid_perf: got %0d exp 0", perf_stall); end
    @(negedge clk); clrn = 1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      inst = mk(5'(i), 5'(i), 5'd0); d_usesrs = 1; d_usesrt = 1;
      @(posedge clk); #1;
      checks++;
      if (e_a !== 32'h0 || e_b !== 32'h0) begin
        errors++; $display("FAIL mid_rf_r%0d: got a=%h b=%h exp 0 0", i, e_a, e_b);
      end
    end
  endtask

  initial begin
    clrn = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); clrn = 1;
    test_fwd_priority();
    test_load_use();
    test_r0_guard();
    test_branch();
    test_flush_hazard();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode stage with an integrated ID/EX pipeline register. It reads the register file and resolves RAW hazards by forwarding from EX, MEM and WB. It detects load-use hazards and stalls for them, compares branch operands early, and inserts bubbles on stall or flush. It sits between the IF/ID register and EX. It takes pre-decoded control from the existing control unit and feeds EX directly from registered outputs.

## Interface
- DW, 32, data/register width
- AW, 5, register address width; 2^AW registers; r0 reads as zero
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- pc4, inst  in  32  PC+4 and instruction of the ID slot; fields: rs=inst[9:5], rt=inst[4:0], rd=inst[14:10], imm16=inst[25:10], jimm=inst[25:0]; upper AW-5 address bits zero
- d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_regrt, d_sext  in  1  decoded controls
- d_aluc  in  3  ALU control
- d_usesrs, d_usesrt  in  1  instruction reads rs / rt
- ex_wreg, ex_m2reg  in  1;  ex_rn  in  AW;  ex_alu  in  DW  EX-stage producer
- mem_wreg, mem_m2reg  in  1;  mem_rn  in  AW;  mem_alu, mem_mdo  in  DW  MEM-stage producer
- wb_wreg  in  1;  wb_rn  in  AW;  wdi  in  DW  write-back port
- flush  in  1  squash the ID-slot instruction
- stall  out  1  hold PC and IF/ID (combinational)
- rsrtequ  out  1  forwarded rs operand == forwarded rt operand (combinational)
- bpc, jpc  out  32  branch/jump targets (combinational)
- e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift  out  1  registered
- e_aluc  out  3;  e_rn  out  AW;  e_a, e_b, e_imm  out  DW  registered
- perf_stall  out  16  stall-cycle counter

## Operation
- Register file:
  - Written at the rising edge of `clk` when wb_wreg=1 and wb_rn!=0.
  - r0 is never written.
  - All registers clear to 0 on clrn=0.
- Operand select for r in {rs, rt}, highest priority first:
  - r==0 → 0.
  - ex_wreg & ~ex_m2reg & ex_rn==r → ex_alu.
  - mem_wreg & mem_rn==r → mem_m2reg ? mem_mdo : mem_alu.
  - wb_wreg & wb_rn==r → wdi.
  - Otherwise → register array.
- Load-use hazard: ex_wreg & ex_m2reg & ex_rn!=0 & ((d_usesrs & ex_rn==rs) | (d_usesrt & ex_rn==rt)).
- stall = hazard & ~flush.
- Destination register: e_rn source = d_regrt ? rt : rd.
- Immediate: imm = {(DW-16) copies of (d_sext & inst[25]), inst[25:10]}.
- bpc = pc4 + {sign-ext imm16, 2'b00}, 32-bit, wrapping.
- jpc = {pc4[31:28], inst[25:0], 2'b00}.
- ID/EX load, every rising edge:
  - flush | hazard: bubble. e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift=0; e_aluc, e_rn, e_a, e_b, e_imm=0.
  - Otherwise: e_valid=1 and all fields take the decoded/forwarded values.
- Flush and hazard in the same cycle: bubble inserted and stall=0 (flush wins).
- perf_stall increments on each edge where stall=1 and saturates at 16'hFFFF.

## Timing
- Reset (clrn=0, asynchronous):
  - Every e_* output is 0, so e_valid=0.
  - perf_stall=0.
  - Register file is all 0.
- Combinational outputs (stall, rsrtequ, bpc, jpc) are valid in the same cycle as their inputs.
- ID/EX latency is 1 cycle.
- A register-file write is visible to ID in the same cycle via the WB bypass, and from the array on the next cycle.
- A load-use stall lasts exactly 1 cycle: the load moves to MEM and is then forwarded from mem_mdo.
- A branch in ID that depends on an EX ALU result uses ex_alu combinationally and does not stall.
- Reset mid-operation discards the pipeline register and register-file contents immediately.

## Test plan
- Reset check: pulse clrn low mid-run → all e_* and perf_stall read 0; reading r1..r31 afterwards returns 0.
- Forward priority:
  - Setup: WB writes r3=0x11, MEM has r3=0x22 (ALU), EX has r3=0x33 (ALU).
  - Issue add using rs=3 → e_a=0x33.
  - Remove the EX producer → e_a=0x22.
  - Remove the MEM producer → e_a=0x11.
- Load-use:
  - Stimulus: EX has a load to r5, ID has an instruction using rt=5.
  - Expected: stall=1 for 1 cycle and a bubble is inserted (e_valid=0).
  - Next cycle, with mem_mdo=0xDEADBEEF: e_b=0xDEADBEEF, e_valid=1, perf_stall=1.
- r0 guard: EX writes r0 with ex_alu=0x55 and ID reads rs=0 → e_a=0, stall=0.
- Branch compare and targets:
  - Stimulus: r1=r2=7, pc4=0x100, imm16=0xFFFF, d_sext=1.
  - Expected: rsrtequ=1 and bpc=0xFC.
  - With inst[25:0]=0x10 and pc4=0x100: jpc=0x40.
- Flush vs hazard: assert flush together with a load-use hazard → stall=0, e_valid=0, and perf_stall is unchanged.
